// File: rtl/reg_fetch.sv
// -----------------------------------------------------------------------------
// reg_fetch
//
// Register-fetch / forward stage for the SPU even pipe. It holds the
// NUM_REGS x 128-bit general register file and reads both source operands of
// the decoded instruction. It bypasses in-flight results from the execute
// staging taps and the write-back port, then registers the operand bundle for
// the execute units. It also commits write-back results to the register file.
//
// Ports
//   clk            pipeline clock, all state updates on the rising edge
//   reset          asynchronous, active-low; clears every register immediately
//   dec_valid      a decoded instruction is present this cycle
//   dec_op         decoded opcode
//   dec_format     instruction format
//   dec_ra_addr    source register A address
//   dec_rb_addr    source register B address
//   dec_rt_addr    destination register address
//   dec_imm        immediate field
//   dec_reg_write  instruction writes rt
//   fwd_rt         results held in the execute staging registers (tap 0 youngest)
//   fwd_rt_addr    destination address of each tap
//   fwd_reg_write  tap holds a real register write
//   rt_wb          write-back value
//   rt_addr_wb     write-back destination
//   reg_write_wb   commit rt_wb this cycle
//   op, format, rt_addr, imm, reg_write   registered instruction fields
//   ra, rb         registered, forwarded source operand values
// -----------------------------------------------------------------------------
module reg_fetch #(
  parameter int NUM_REGS = 128,
  parameter int FWD_TAPS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_valid,
  input  logic [0:10]                  dec_op,
  input  logic [2:0]                   dec_format,
  input  logic [0:6]                   dec_ra_addr,
  input  logic [0:6]                   dec_rb_addr,
  input  logic [0:6]                   dec_rt_addr,
  input  logic [0:17]                  dec_imm,
  input  logic                         dec_reg_write,
  input  logic [FWD_TAPS-1:0][0:127]   fwd_rt,
  input  logic [FWD_TAPS-1:0][0:6]     fwd_rt_addr,
  input  logic [FWD_TAPS-1:0]          fwd_reg_write,
  input  logic [0:127]                 rt_wb,
  input  logic [0:6]                   rt_addr_wb,
  input  logic                         reg_write_wb,
  output logic [0:10]                  op,
  output logic [2:0]                   format,
  output logic [0:6]                   rt_addr,
  output logic [0:127]                 ra,
  output logic [0:127]                 rb,
  output logic [0:17]                  imm,
  output logic                         reg_write
);

  logic [0:127] r_regs [0:NUM_REGS-1];

  logic [0:127] w_raFile;
  logic [0:127] w_rbFile;
  logic [0:127] w_raSel;
  logic [0:127] w_rbSel;

  // Priority bypass for one source operand. The write-back port is applied
  // first and the taps are then applied from the oldest to the youngest, so
  // the youngest matching tap overrides everything else and a tap always
  // beats the write-back port on the same address.
  function automatic logic [0:127] selectOperand(
    input logic [0:6]                 addr,
    input logic [0:127]               fileVal,
    input logic [FWD_TAPS-1:0][0:127] tapVal,
    input logic [FWD_TAPS-1:0][0:6]   tapAddr,
    input logic [FWD_TAPS-1:0]        tapWe,
    input logic [0:127]               wbVal,
    input logic [0:6]                 wbAddr,
    input logic                       wbWe
  );
    logic [0:127] v;
    v = fileVal;
    if (wbWe && (wbAddr == addr)) begin
      v = wbVal;
    end
    for (int k = FWD_TAPS - 1; k >= 0; k--) begin
      if (tapWe[k] && (tapAddr[k] == addr)) begin
        v = tapVal[k];
      end
    end
    return v;
  endfunction

  // Register file: no hardwired register; a write pending at reset is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (reg_write_wb) begin
      r_regs[rt_addr_wb] <= rt_wb;
    end
  end

  always_comb begin
    w_raFile = r_regs[dec_ra_addr];
    w_rbFile = r_regs[dec_rb_addr];
  end

  // ra and rb are selected independently, so equal addresses give equal values.
  always_comb begin
    w_raSel = selectOperand(dec_ra_addr, w_raFile, fwd_rt, fwd_rt_addr,
                            fwd_reg_write, rt_wb, rt_addr_wb, reg_write_wb);
    w_rbSel = selectOperand(dec_rb_addr, w_rbFile, fwd_rt, fwd_rt_addr,
                            fwd_reg_write, rt_wb, rt_addr_wb, reg_write_wb);
  end

  // Output bundle. An empty decode slot becomes an all-zero nop so the
  // execute units never see stale fields or a spurious write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      ra        <= '0;
      rb        <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
    end else if (dec_valid) begin
      op        <= dec_op;
      format    <= dec_format;
      rt_addr   <= dec_rt_addr;
      ra        <= w_raSel;
      rb        <= w_rbSel;
      imm       <= dec_imm;
      reg_write <= dec_reg_write;
    end else begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      ra        <= '0;
      rb        <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_fetch.sv
// -----------------------------------------------------------------------------
// tb_reg_fetch
//
// Self-checking bench for reg_fetch. A behavioural model holds the register
// file as a plain array and resolves each operand by scanning the taps, then
// the write-back port, then the array. Directed scenarios are followed by a
// randomized stream and a mid-stream asynchronous reset.
// -----------------------------------------------------------------------------
module tb_reg_fetch;

  localparam int NUM_REGS = 128;
  localparam int FWD_TAPS = 3;

  logic                       clk;
  logic                       reset;
  logic                       dec_valid;
  logic [0:10]                dec_op;
  logic [2:0]                 dec_format;
  logic [0:6]                 dec_ra_addr;
  logic [0:6]                 dec_rb_addr;
  logic [0:6]                 dec_rt_addr;
  logic [0:17]                dec_imm;
  logic                       dec_reg_write;
  logic [FWD_TAPS-1:0][0:127] fwd_rt;
  logic [FWD_TAPS-1:0][0:6]   fwd_rt_addr;
  logic [FWD_TAPS-1:0]        fwd_reg_write;
  logic [0:127]               rt_wb;
  logic [0:6]                 rt_addr_wb;
  logic                       reg_write_wb;
  logic [0:10]                op;
  logic [2:0]                 format;
  logic [0:6]                 rt_addr;
  logic [0:127]               ra;
  logic [0:127]               rb;
  logic [0:17]                imm;
  logic                       reg_write;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem [NUM_REGS];

  logic [127:0] expOp, expFormat, expRtAddr, expRa, expRb, expImm, expRegWrite;

  reg_fetch #(.NUM_REGS(NUM_REGS), .FWD_TAPS(FWD_TAPS)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_format(dec_format),
    .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr),
    .dec_rt_addr(dec_rt_addr), .dec_imm(dec_imm),
    .dec_reg_write(dec_reg_write),
    .fwd_rt(fwd_rt), .fwd_rt_addr(fwd_rt_addr), .fwd_reg_write(fwd_reg_write),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .op(op), .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb),
    .imm(imm), .reg_write(reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference operand: first matching live tap, else the write-back port,
  // else the stored register value.
  function automatic logic [127:0] modelOperand(input logic [0:6] addr);
    for (int k = 0; k < FWD_TAPS; k++) begin
      if (fwd_reg_write[k] && fwd_rt_addr[k] == addr) return fwd_rt[k];
    end
    if (reg_write_wb && rt_addr_wb == addr) return rt_wb;
    return mem[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBundle(input string tag);
    checkOutput({tag, "_op"},        128'(op),        expOp);
    checkOutput({tag, "_format"},    128'(format),    expFormat);
    checkOutput({tag, "_rtaddr"},    128'(rt_addr),   expRtAddr);
    checkOutput({tag, "_ra"},        128'(ra),        expRa);
    checkOutput({tag, "_rb"},        128'(rb),        expRb);
    checkOutput({tag, "_imm"},       128'(imm),       expImm);
    checkOutput({tag, "_regwrite"},  128'(reg_write), expRegWrite);
  endtask

  // Predict the bundle from the current inputs, clock once, update the
  // model's register file, then compare one time unit after the edge.
  task automatic applyStimulus(input string tag);
    if (reset && dec_valid) begin
      expOp       = 128'(dec_op);
      expFormat   = 128'(dec_format);
      expRtAddr   = 128'(dec_rt_addr);
      expRa       = modelOperand(dec_ra_addr);
      expRb       = modelOperand(dec_rb_addr);
      expImm      = 128'(dec_imm);
      expRegWrite = 128'(dec_reg_write);
    end else begin
      expOp = '0; expFormat = '0; expRtAddr = '0; expRa = '0;
      expRb = '0; expImm = '0; expRegWrite = '0;
    end
    @(posedge clk);
    if (reset && reg_write_wb) mem[rt_addr_wb] = rt_wb;
    #1;
    checkBundle(tag);
  endtask

  task automatic clearInputs();
    dec_valid = 0; dec_op = '0; dec_format = '0; dec_ra_addr = '0;
    dec_rb_addr = '0; dec_rt_addr = '0; dec_imm = '0; dec_reg_write = 0;
    fwd_rt = '0; fwd_rt_addr = '0; fwd_reg_write = '0;
    rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 0;
  endtask

  task automatic decodeRead(input logic [0:6] a, input logic [0:6] b);
    dec_valid = 1; dec_op = 11'h155; dec_format = 3'd2; dec_rt_addr = 7'd1;
    dec_imm = 18'h2A5A5; dec_reg_write = 1; dec_ra_addr = a; dec_rb_addr = b;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    clearInputs();
    reset = 0;
    #12;
    expOp = '0; expFormat = '0; expRtAddr = '0; expRa = '0;
    expRb = '0; expImm = '0; expRegWrite = '0;
    checkBundle("reset_init");
    reset = 1;

    // Write then read: reg 5 written, then decoded the next cycle.
    reg_write_wb = 1; rt_addr_wb = 7'd5; rt_wb = {16{8'hA5}};
    applyStimulus("wb_reg5");
    clearInputs();
    decodeRead(7'd5, 7'd0);
    applyStimulus("read_reg5");
    checkOutput("read_reg5_const", 128'(ra), {16{8'hA5}});

    // Same-cycle bypass from the write-back port to both operands.
    clearInputs();
    decodeRead(7'd9, 7'd9);
    reg_write_wb = 1; rt_addr_wb = 7'd9; rt_wb = 128'h1234;
    applyStimulus("bypass_wb");
    checkOutput("bypass_wb_ra_const", 128'(ra), 128'h1234);
    checkOutput("bypass_wb_rb_const", 128'(rb), 128'h1234);

    // Tap priority: tap0 over tap2 over write-back.
    clearInputs();
    decodeRead(7'd3, 7'd3);
    fwd_rt_addr[0] = 7'd3; fwd_rt[0] = 128'h1; fwd_reg_write[0] = 1;
    fwd_rt_addr[2] = 7'd3; fwd_rt[2] = 128'h2; fwd_reg_write[2] = 1;
    reg_write_wb = 1; rt_addr_wb = 7'd3; rt_wb = 128'h3;
    applyStimulus("tap_prio0");
    checkOutput("tap_prio0_const", 128'(ra), 128'h1);
    fwd_reg_write[0] = 0;
    applyStimulus("tap_prio2");
    checkOutput("tap_prio2_const", 128'(ra), 128'h2);

    // A tap with its write enable low is ignored.
    clearInputs();
    reg_write_wb = 1; rt_addr_wb = 7'd7; rt_wb = 128'h55;
    applyStimulus("wb_reg7");
    clearInputs();
    decodeRead(7'd7, 7'd7);
    fwd_rt_addr[1] = 7'd7; fwd_rt[1] = 128'hDEAD; fwd_reg_write[1] = 0;
    applyStimulus("ignored_tap");
    checkOutput("ignored_tap_const", 128'(ra), 128'h55);

    // Nop injection followed by cntb passing through.
    clearInputs();
    dec_valid = 0; dec_op = 11'b01010110100; dec_format = 3'd0;
    dec_ra_addr = 7'd5; dec_rb_addr = 7'd7; dec_rt_addr = 7'd12;
    dec_imm = 18'h3FFFF; dec_reg_write = 1;
    applyStimulus("nop");
    checkOutput("nop_op_const", 128'(op), 128'h0);
    dec_valid = 1;
    applyStimulus("cntb");
    checkOutput("cntb_op_const", 128'(op), 128'(11'b01010110100));

    // Randomized stream; small address range makes collisions frequent.
    for (int n = 0; n < 150; n++) begin
      dec_valid     = ($urandom_range(0, 3) != 0);
      dec_op        = 11'($urandom);
      dec_format    = 3'($urandom);
      dec_ra_addr   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      dec_rb_addr   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      dec_rt_addr   = 7'($urandom);
      dec_imm       = 18'($urandom);
      dec_reg_write = 1'($urandom);
      for (int k = 0; k < FWD_TAPS; k++) begin
        fwd_rt[k]        = rand128();
        fwd_rt_addr[k]   = 7'($urandom_range(0, 7));
        fwd_reg_write[k] = ($urandom_range(0, 2) == 0);
      end
      rt_wb        = rand128();
      rt_addr_wb   = 7'($urandom_range(0, 9));
      reg_write_wb = ($urandom_range(0, 1) == 1);
      applyStimulus("random");
    end

    // Mid-stream asynchronous reset with a valid decode and a pending write.
    clearInputs();
    decodeRead(7'd5, 7'd3);
    reg_write_wb = 1; rt_addr_wb = 7'd4; rt_wb = 128'hFACE;
    applyStimulus("pre_reset");
    #2;
    reset = 0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    expOp = '0; expFormat = '0; expRtAddr = '0; expRa = '0;
    expRb = '0; expImm = '0; expRegWrite = '0;
    checkBundle("async_reset");
    applyStimulus("in_reset");
    reset = 1;
    clearInputs();
    decodeRead(7'd5, 7'd4);
    applyStimulus("post_reset_a");
    checkOutput("post_reset_ra_const", 128'(ra), 128'h0);
    checkOutput("post_reset_rb_const", 128'(rb), 128'h0);
    decodeRead(7'd9, 7'd7);
    applyStimulus("post_reset_b");
    decodeRead(7'd3, 7'd1);
    applyStimulus("post_reset_c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
